// File: rtl/player_input_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | player_input_pkg: shared constants for the player input encoder |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package player_input_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SEL   = 4;
  localparam int NUM_BTN   = 5;

  localparam logic [7:0] PORT_ENC1 = 8'h00;
  localparam logic [7:0] PORT_ENC2 = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Millisecond counters stick at all-ones rather than wrapping.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ms_tick_gen: one-cycle pulse every CLK_PER_MS clocks            |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module ms_tick_gen #(
  parameter int CLK_PER_MS = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/player_input_enc.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | player_input_enc: sync/debounce buttons into sticky event bits  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module player_input_enc
  import player_input_pkg::*;
#(
  parameter int         CLK_PER_MS  = 100000,
  parameter int         DEBOUNCE_MS = 5,
  parameter int         HOLD_MS     = 400,
  parameter int         REPEAT_MS   = 100,
  parameter bit         REPEAT_EN   = 1'b1,
  parameter logic [7:0] PORT_ID     = PORT_ENC1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   btn_raw,
  input  logic [7:0]   port_id,
  input  logic         read_strobe,
  output logic [4:0]   enc,
  output logic [4:0]   btn_db
);

  localparam logic [9:0] DB_LAST   = 10'(DEBOUNCE_MS - 1);
  localparam logic [9:0] HOLD_LAST = 10'(HOLD_MS - 1);
  localparam logic [9:0] RPT_LAST  = 10'(REPEAT_MS - 1);

  logic       tick;
  logic [4:0] sync_a;
  logic [4:0] sync;
  logic [4:0] db_q;
  logic [4:0] press;
  logic [3:0] rpt_set;
  logic [4:0] set;
  logic       clr;

  ms_tick_gen #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync   <= '0;
      db_q   <= '0;
    end else begin
      sync_a <= btn_raw;
      sync   <= sync_a;
      db_q   <= btn_db;
    end
  end

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
      logic       db;
      logic [9:0] dcnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          db   <= 1'b0;
          dcnt <= '0;
        end else if (sync[i] == db) begin
          dcnt <= '0;
        end else if (tick) begin
          if (dcnt == DB_LAST) begin
            db   <= sync[i];
            dcnt <= '0;
          end else begin
            dcnt <= sat_inc10(dcnt);
          end
        end
      end

      assign btn_db[i] = db;
    end
  endgenerate

  assign press = btn_db & ~db_q;

  generate
    if (REPEAT_EN) begin : g_rpt
      for (genvar d = BTN_UP; d <= BTN_RIGHT; d++) begin : g_dir
        rpt_state_t state, state_nx;
        logic [9:0] rcnt, rcnt_nx;
        logic       fire;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            state <= IDLE;
            rcnt  <= '0;
          end else begin
            state <= state_nx;
            rcnt  <= rcnt_nx;
          end
        end

        always_comb begin
          state_nx = state;
          rcnt_nx  = rcnt;
          fire     = 1'b0;
          case (state)
            IDLE: begin
              if (press[d]) begin
                state_nx = HOLD;
                rcnt_nx  = '0;
              end
            end
            HOLD: begin
              if (tick) begin
                if (rcnt == HOLD_LAST) begin
                  fire     = 1'b1;
                  rcnt_nx  = '0;
                  state_nx = REPEAT;
                end else begin
                  rcnt_nx = sat_inc10(rcnt);
                end
              end
            end
            REPEAT: begin
              if (tick) begin
                if (rcnt == RPT_LAST) begin
                  fire    = 1'b1;
                  rcnt_nx = '0;
                end else begin
                  rcnt_nx = sat_inc10(rcnt);
                end
              end
            end
            default: state_nx = IDLE;
          endcase
          // Releasing the button overrides everything, including a due repeat.
          if (!btn_db[d]) begin
            state_nx = IDLE;
            rcnt_nx  = '0;
            fire     = 1'b0;
          end
        end

        assign rpt_set[d] = fire;
      end
    end else begin : g_no_rpt
      assign rpt_set = '0;
    end
  endgenerate

  assign set = press | {1'b0, rpt_set};
  assign clr = read_strobe && (port_id == PORT_ID);

  // Set is ORed after the clear so an event landing in the read cycle survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      enc <= '0;
    else
      enc <= (clr ? 5'b0 : enc) | set;
  end

endmodule
`default_nettype wire

// File: tb/tb_player_input_enc.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_player_input_enc: directed checks of the player input encoder|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_player_input_enc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn_raw = 5'h00;
  logic [7:0] port_id = 8'h00;
  logic       read_strobe = 1'b0;
  logic [4:0] enc, btn_db, enc_nr, btn_db_nr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  player_input_enc #(
    .CLK_PER_MS(10), .DEBOUNCE_MS(2), .HOLD_MS(5), .REPEAT_MS(3),
    .REPEAT_EN(1'b1), .PORT_ID(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .port_id(port_id),
    .read_strobe(read_strobe), .enc(enc), .btn_db(btn_db)
  );

  player_input_enc #(
    .CLK_PER_MS(10), .DEBOUNCE_MS(2), .HOLD_MS(5), .REPEAT_MS(3),
    .REPEAT_EN(1'b0), .PORT_ID(8'h00)
  ) dut_nr (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .port_id(port_id),
    .read_strobe(read_strobe), .enc(enc_nr), .btn_db(btn_db_nr)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Three reset cycles; returns 1 ns after the last reset edge (edge E0).
  task automatic do_reset(input logic [4:0] raw);
    btn_raw     = raw;
    read_strobe = 1'b0;
    port_id     = 8'h00;
    reset       = 1'b1;
    step(3);
    chk("rst_enc", enc, 5'h00);
    chk("rst_db", btn_db, 5'h00);
    chk("rst_enc_nr", enc_nr, 5'h00);
    reset = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] exp_r, exp_nr;

    // Reset with all buttons held: debounced at tick E20, events at E21.
    do_reset(5'h1F);
    step(19);
    chk("db_before_deb", btn_db, 5'h00);
    step(1);
    chk("db_after_deb", btn_db, 5'h1F);
    chk("enc_at_deb", enc, 5'h00);
    step(1);
    chk("enc_press_all", enc, 5'h1F);
    chk("enc_nr_press_all", enc_nr, 5'h1F);

    // Read of the other player's port leaves events alone; own port clears.
    port_id = 8'h01; read_strobe = 1'b1;
    step(1);
    chk("rd_other_port", enc, 5'h1F);
    port_id = 8'h00;
    step(1);
    chk("rd_own_port", enc, 5'h00);
    chk("rd_own_port_nr", enc_nr, 5'h00);
    read_strobe = 1'b0;
    step(46);
    chk("pre_hold", enc, 5'h00);
    step(1);
    chk("hold_fire_dirs", enc, 5'h0F);
    chk("hold_nr_quiet", enc_nr, 5'h00);

    // Select bouncing every 7 cycles, then stable high from E56.
    do_reset(5'h00);
    for (int i = 0; i < 9; i++) begin
      btn_raw[4] = (i % 2 == 0);
      step(7);
      chk("bounce_enc", enc, 5'h00);
    end
    step(7);
    chk("bounce_db", btn_db, 5'h10);
    chk("bounce_enc_pre", enc, 5'h00);
    step(1);
    chk("bounce_enc_sel", enc, 5'h10);
    read_strobe = 1'b1;
    step(1);
    read_strobe = 1'b0;
    chk("sel_cleared", enc, 5'h00);
    step(60);
    chk("sel_no_repeat", enc, 5'h00);

    // Bit 2 press lands in the same cycle as a clearing read of bit 0.
    do_reset(5'b00001);
    step(21);
    chk("coll_pre", enc, 5'b00001);
    btn_raw = 5'b00100;
    step(19);
    chk("coll_before", enc, 5'b00001);
    read_strobe = 1'b1;
    step(1);
    read_strobe = 1'b0;
    chk("coll_set_wins", enc, 5'b00100);
    chk("coll_db", btn_db, 5'b00100);
    step(29);
    chk("coll_up_idle", enc, 5'b00100);

    // Right held ~15.6 ms with a read every ms; events at E21/E70/E100/E130/E160.
    do_reset(5'h00);
    btn_raw = 5'b01000;
    step(5);
    for (int k = 0; k < 20; k++) begin
      exp_r  = (k == 2 || k == 7 || k == 10 || k == 13 || k == 16) ? 5'b01000 : 5'b00000;
      exp_nr = (k == 2) ? 5'b01000 : 5'b00000;
      chk("rpt_read", enc, exp_r);
      chk("rpt_read_nr", enc_nr, exp_nr);
      read_strobe = 1'b1;
      step(1);
      read_strobe = 1'b0;
      if (k == 15) btn_raw = 5'h00;
      step(9);
    end
    chk("rpt_released_db", btn_db, 5'h00);

    // Reset while up is auto-repeating; button stays held through reset.
    do_reset(5'h00);
    btn_raw = 5'b00001;
    step(105);
    chk("mid_pre_enc", enc, 5'b00001);
    chk("mid_pre_db", btn_db, 5'b00001);
    do_reset(5'b00001);
    step(20);
    chk("mid_redeb_db", btn_db, 5'b00001);
    chk("mid_redeb_enc0", enc, 5'h00);
    step(1);
    chk("mid_fresh_event", enc, 5'b00001);
    read_strobe = 1'b1;
    step(1);
    read_strobe = 1'b0;
    chk("mid_cleared", enc, 5'h00);
    step(47);
    chk("mid_hold_restart_pre", enc, 5'h00);
    step(1);
    chk("mid_hold_restart", enc, 5'b00001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
